led_mode_controller: RTL
========================

# led_mode_controller

Sequencer that drives the board's 4 user LEDs through a fixed set of display modes. It sits between the button debounce stage and the `led` pins: each single-cycle debounced button pulse advances the mode, and an internal prescaler paces the per-mode LED animation. It replaces direct count-to-LED wiring, with every register in the `sysclk` domain.

## Interface
- `TICK_DIV`, default 31_250_000 (4 Hz at 125 MHz): sysclk cycles per animation step; legal range ≥ 2; prescaler width = $clog2(TICK_DIV)
- `sysclk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset; one clock, no other clock domains
- `btn_pulse`  in  1  one-cycle pulse per press, from debounce, synchronous to sysclk
- `hold`  in  1  level; 1 freezes the prescaler and animation
- `led`  out  4  registered LED drive
- `mode`  out  2  registered current mode: 0 OFF, 1 COUNT, 2 SHIFT, 3 BLINK
- `tick`  out  1  registered; high for one cycle after each animation step edge

## Operation
- Mode FSM: OFF→COUNT→SHIFT→BLINK→OFF, one step per `btn_pulse`; no other transitions.
- Entry values, loaded on the same edge as the mode change: OFF 0000, COUNT 0000, SHIFT 0001, BLINK 1111.
- Prescaler `div_cnt` counts 0..TICK_DIV-1 and runs in every mode, including OFF.
- Terminal edge is an edge with `div_cnt == TICK_DIV-1`, `hold == 0` and `btn_pulse == 0`. On that edge:
  - `div_cnt` ← 0
  - `tick` ← 1
  - `led` steps per mode:
    - OFF: stays 0000
    - COUNT: `led` + 1, 4-bit modulo; 1111 wraps to 0000
    - SHIFT: rotate left; 1000 wraps to 0001
    - BLINK: bitwise invert; 1111 ↔ 0000
- On every edge that is not a terminal edge, `tick` ← 0.
- If `hold == 1`:
  - `div_cnt` and `led` are frozen and `tick` = 0.
  - `btn_pulse` is still honoured.
  - On release, counting resumes from the frozen `div_cnt` value.
- If `btn_pulse == 1`:
  - `div_cnt` ← 0 and `mode` advances.
  - `led` loads the entry value of the new mode and `tick` ← 0.
  - This overrides a coincident terminal count; that step is dropped.
- A `btn_pulse` held high for k cycles advances the mode k times; the block does not edge-detect.

## Timing
- Reset values: `mode` = 0 (OFF), `led` = 0000, `tick` = 0, `div_cnt` = 0.
- While `reset` is high, all inputs are ignored, and `reset` overrides `btn_pulse` and `hold`.
- Reset asserted mid-animation or mid-hold returns to the reset values on the next edge.
- Mode latency: `btn_pulse` sampled high at edge N gives new `mode` and entry `led` after edge N (1 cycle).
- First step after mode entry or reset release: exactly TICK_DIV edges later, with no hold.
- Step period is TICK_DIV cycles. `tick` is high during the cycle following each step edge, aligned with the new `led` value.
- With hold asserted for H cycles, the step is delayed by exactly H cycles.
- Outputs are driven only by registers, with no combinational path from input to output.

## Test plan
- With TICK_DIV=4, apply reset then release it, with no pulses for 12 cycles. Required: `mode` = 0, `led` = 0000 throughout, and `tick` pulses at cycles 4, 8, 12 after release.
- Issue one `btn_pulse` (COUNT) and run 68 cycles. Required: after the pulse edge `led` = 0000; it then steps 1, 2, … every 4 cycles, wraps 1111→0000 at step 16, and shows 0001 at step 17.
- Issue two pulses to reach SHIFT and run 20 cycles. Required: `led` = 0001, then 0010, 0100, 1000, 0001, with `tick` coincident with each change.
- In BLINK (`led` = 1111), assert `hold` for 10 cycles from `div_cnt` = 2. Required: `led` stays 1111 with `tick` = 0, and after release it toggles to 0000 after 2 further cycles.
- Assert `btn_pulse` on the terminal-count edge in COUNT with `led` = 0101. Required: `mode` = 2, `led` = 0001, `tick` = 0, and the next step occurs 4 cycles later.
- Assert `reset` while in SHIFT with `btn_pulse` = 1 in the same cycle. Required: `mode` = 0, `led` = 0000, `tick` = 0, and the pulse is ignored.

Source files
------------

// File: rtl/led_mode_controller.sv
// Purpose: steps the 4 user LEDs through OFF/COUNT/SHIFT/BLINK display modes, advanced by debounced button pulses.
// Latency: a button pulse changes mode/led after 1 edge; animation steps every TICK_DIV edges of non-held time.
// Backpressure: none; hold freezes the prescaler and animation while button pulses are still honoured.
module led_mode_controller #(
    parameter int TICK_DIV = 31_250_000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       btn_pulse,
    input  logic       hold,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int             DW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_MAX = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_COUNT = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    mode_t          r_mode;
    mode_t          w_mode_nxt;
    logic [3:0]     r_led;
    logic [3:0]     w_led_nxt;
    logic [DW-1:0]  r_div_cnt;
    logic [DW-1:0]  w_div_nxt;
    logic           r_tick;
    logic           w_tick_nxt;
    logic           w_terminal;

    // A terminal edge only counts when neither hold nor a button press claims the cycle.
    assign w_terminal = (r_div_cnt == DIV_MAX) && !hold && !btn_pulse;

    // State register: mode, LED pattern, prescaler and tick strobe, all reset together.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_mode    <= MODE_OFF;
            r_led     <= 4'b0000;
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_led     <= w_led_nxt;
            r_div_cnt <= w_div_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    // Next state: a button press wins over everything, then hold, then normal prescaler stepping.
    always_comb begin
        w_mode_nxt = r_mode;
        w_led_nxt  = r_led;
        w_div_nxt  = r_div_cnt;
        w_tick_nxt = 1'b0;

        if (btn_pulse) begin
            // Mode advance restarts the step period and loads the new mode's entry pattern.
            w_div_nxt = '0;
            case (r_mode)
                MODE_OFF: begin
                    w_mode_nxt = MODE_COUNT;
                    w_led_nxt  = 4'b0000;
                end
                MODE_COUNT: begin
                    w_mode_nxt = MODE_SHIFT;
                    w_led_nxt  = 4'b0001;
                end
                MODE_SHIFT: begin
                    w_mode_nxt = MODE_BLINK;
                    w_led_nxt  = 4'b1111;
                end
                default: begin
                    w_mode_nxt = MODE_OFF;
                    w_led_nxt  = 4'b0000;
                end
            endcase
        end else if (!hold) begin
            if (w_terminal) begin
                w_div_nxt  = '0;
                w_tick_nxt = 1'b1;
                case (r_mode)
                    MODE_OFF:   w_led_nxt = 4'b0000;
                    MODE_COUNT: w_led_nxt = r_led + 4'd1;
                    MODE_SHIFT: w_led_nxt = {r_led[2:0], r_led[3]};
                    default:    w_led_nxt = ~r_led;
                endcase
            end else begin
                w_div_nxt = r_div_cnt + DW'(1);
            end
        end
    end

    assign led  = r_led;
    assign mode = r_mode;
    assign tick = r_tick;

endmodule
